// File: rtl/bus_trace_window.sv
// bus_trace_window: 6502 bus observer with prioritised address windows and a trace FIFO.
// Optional BUS_TRACE_TIMESTAMP_EN adds the rd_stamp field to each record.
module bus_trace_window #(
  parameter int NWIN = 4,
  parameter int DEPTH = 16,
  parameter int AW = 16,
  parameter int DW = 8,
  localparam int WW = $clog2(NWIN + 1),
  localparam int CW = $clog2(DEPTH + 1)
)(
  input  logic               CLK25MHZ,
  input  logic               rst_n,
  input  logic               PHI2,
  input  logic               RW,
  input  logic               SYNC,
  input  logic [AW-1:0]      A,
  input  logic [DW-1:0]      D,
  input  logic [NWIN*AW-1:0] win_mask,
  input  logic [NWIN*AW-1:0] win_pattern,
  input  logic [NWIN-1:0]    win_en,
  input  logic               capture_all,
  output logic [NWIN-1:0]    cs_n,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [AW-1:0]      rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic               rd_rw,
  output logic               rd_sync,
  output logic [WW-1:0]      rd_win,
  output logic [CW-1:0]      fifo_count,
  output logic               overflow,
  input  logic               clr_overflow,
`ifdef BUS_TRACE_TIMESTAMP_EN
  output logic [15:0]        rd_stamp,
`endif
  output logic [15:0]        cycle_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = AW + DW + 2 + WW;
`ifdef BUS_TRACE_TIMESTAMP_EN
  localparam int RECW = LW + 16;
`else
  localparam int RECW = LW;
`endif

  function automatic logic [WW-1:0] first_hit(input logic [NWIN-1:0] m);
    first_hit = WW'(NWIN);
    for (int i = NWIN - 1; i >= 0; i--) if (m[i]) first_hit = WW'(i);
  endfunction

  logic [AW+DW+2:0] s1_q, s2_q;
  logic             phi2_s, rw_s, sync_s;
  logic [AW-1:0]    a_s;
  logic [DW-1:0]    d_s;
  logic [NWIN-1:0]  raw_m, syn_m;
  logic [WW-1:0]    raw_win, syn_win;
  logic [1:0]       edge_q;
  logic [15:0]      cc_q;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [RECW-1:0]  out_q, out_d, rec;
  logic [RECW-1:0]  mem [DEPTH];
  logic             fall, push, pop, push_ok;

  assign {phi2_s, rw_s, sync_s, a_s, d_s} = s2_q;

  for (genvar i = 0; i < NWIN; i++) begin : g_win
    assign raw_m[i] = win_en[i] & ((A & win_mask[i*AW +: AW]) == (win_pattern[i*AW +: AW] & win_mask[i*AW +: AW]));
    assign syn_m[i] = win_en[i] & ((a_s & win_mask[i*AW +: AW]) == (win_pattern[i*AW +: AW] & win_mask[i*AW +: AW]));
    assign cs_n[i]  = ~(PHI2 & (raw_win == WW'(i)));
  end

  assign raw_win = first_hit(raw_m);
  assign syn_win = first_hit(syn_m);

`ifdef BUS_TRACE_TIMESTAMP_EN
  assign rec = {cc_q, a_s, d_s, rw_s, sync_s, syn_win};
  assign rd_stamp = out_q[RECW-1 -: 16];
`else
  assign rec = {a_s, d_s, rw_s, sync_s, syn_win};
`endif

  // The head register lets rd_* keep the last popped record once the FIFO drains.
  always_comb begin
    fall    = edge_q == 2'b10;
    push    = fall & (capture_all | (|syn_m));
    pop     = (cnt_q != '0) & rd_ready;
    push_ok = push & ((cnt_q != CW'(DEPTH)) | pop);
    wp_d    = wp_q + PW'(push_ok);
    rp_d    = rp_q + PW'(pop);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d   = (push & ~push_ok) | (ovf_q & ~clr_overflow);
    out_d   = (cnt_d == '0) ? out_q : (push_ok && wp_q == rp_d) ? rec : mem[rp_d];
  end

  always_ff @(posedge CLK25MHZ or negedge rst_n)
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      edge_q <= '0;
      cc_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      out_q  <= '0;
    end else begin
      s1_q   <= {PHI2, RW, SYNC, A, D};
      s2_q   <= s1_q;
      edge_q <= {edge_q[0], phi2_s};
      cc_q   <= cc_q + 16'(fall);
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      out_q  <= out_d;
    end

  always_ff @(posedge CLK25MHZ)
    if (push_ok) mem[wp_q] <= rec;

  assign {rd_addr, rd_data, rd_rw, rd_sync, rd_win} = out_q[LW-1:0];
  assign rd_valid    = cnt_q != '0;
  assign fifo_count  = cnt_q;
  assign overflow    = ovf_q;
  assign cycle_count = cc_q;
endmodule
